// File: rtl/pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_controller
//
// Sequencing controller for a five-stage MIPS pipeline. Detects load-use
// hazards between ID and EX and stalls the front end for STALL_CYCLES
// cycles. Flushes IF/ID, ID/EX and EX/MEM when a taken branch/jump/jr
// resolves in MEM, and honours an external freeze (hold). Keeps saturating
// stall and flush event counters for debug.
//
// Parameters
//   STALL_CYCLES  bubbles inserted per load-use hazard (1..15)
//   CNT_WIDTH     width of the event counters
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   hold                freezes the whole pipeline
//   id_rs, id_rt        source register fields of the instruction in ID
//   ex_rt, ex_mem_read  destination/MemRead of the instruction in EX
//   mem_redirect        taken branch, jump or jr resolved in MEM
//   pc_write            PC load enable
//   if_id_write         IF/ID load enable
//   if_id_flush         IF/ID loads a bubble
//   id_ex_flush         ID/EX loads a bubble
//   ex_mem_flush        EX/MEM loads a bubble
//   state               0 = RUN, 1 = STALL
//   stall_count         cycles in which a stall bubble was inserted
//   flush_count         redirect flush events
// ---------------------------------------------------------------------------
module pipeline_hazard_controller #(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hold,
  input  logic [4:0]           id_rs,
  input  logic [4:0]           id_rt,
  input  logic [4:0]           ex_rt,
  input  logic                 ex_mem_read,
  input  logic                 mem_redirect,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 ex_mem_flush,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(STALL_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]   flush_cnt_q, flush_cnt_d;
  logic                   hz;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    logic [CNT_WIDTH-1:0] one;
    one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    return (&v) ? v : v + one;
  endfunction

  // $zero is never a real destination, so it can never create a hazard.
  assign hz = ex_mem_read && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;

    if (hold) begin
      // Freeze: nothing loads, all state holds. A pending redirect stays
      // asserted because MEM is frozen too, so it is taken after release.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (mem_redirect) begin
      // Redirect wins over any stall; a stall in progress is abandoned.
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      state_d      = RUN;
      cnt_d        = 4'd0;
      flush_cnt_d  = sat_inc(flush_cnt_q);
    end else if ((state_q == STALL) || hz) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      stall_cnt_d = sat_inc(stall_cnt_q);
      if (state_q == STALL) begin
        // hz is ignored here: the original hazard is still being serviced.
        if (cnt_q == 4'd1) begin
          state_d = RUN;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end else if (STALL_CYCLES > 1) begin
        state_d = STALL;
        cnt_d   = CNT_LOAD;
      end
      // With a single bubble we stay in RUN; next cycle re-evaluates hz
      // with the bubble sitting in EX.
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      cnt_q       <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign state       = state_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       hold;
  logic       ex_mem_read;
  logic       mem_redirect;
  logic [4:0] id_rs, id_rt, ex_rt;

  always #5 clk = ~clk;

  // Instance a: STALL_CYCLES=1, 4-bit counters (saturation reachable quickly)
  logic       pc_a, ifw_a, iff_a, idf_a, exf_a;
  logic [1:0] st_a;
  logic [3:0] sc_a, fc_a;
  // Instance b: STALL_CYCLES=3, 16-bit counters
  logic        pc_b, ifw_b, iff_b, idf_b, exf_b;
  logic [1:0]  st_b;
  logic [15:0] sc_b, fc_b;

  logic [4:0] ctl_a, ctl_b;
  assign ctl_a = {pc_a, ifw_a, iff_a, idf_a, exf_a};
  assign ctl_b = {pc_b, ifw_b, iff_b, idf_b, exf_b};

  pipeline_hazard_controller #(.STALL_CYCLES(1), .CNT_WIDTH(4)) dut_a (
    .clk(clk), .reset(reset), .hold(hold),
    .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt),
    .ex_mem_read(ex_mem_read), .mem_redirect(mem_redirect),
    .pc_write(pc_a), .if_id_write(ifw_a), .if_id_flush(iff_a),
    .id_ex_flush(idf_a), .ex_mem_flush(exf_a), .state(st_a),
    .stall_count(sc_a), .flush_count(fc_a)
  );

  pipeline_hazard_controller #(.STALL_CYCLES(3), .CNT_WIDTH(16)) dut_b (
    .clk(clk), .reset(reset), .hold(hold),
    .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt),
    .ex_mem_read(ex_mem_read), .mem_redirect(mem_redirect),
    .pc_write(pc_b), .if_id_write(ifw_b), .if_id_flush(iff_b),
    .id_ex_flush(idf_b), .ex_mem_flush(exf_b), .state(st_b),
    .stall_count(sc_b), .flush_count(fc_b)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d got %0h want %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Behavioural model: per instance, the number of bubbles still owed
  // after the current one, plus the two event counts.
  int rem  [2];
  int mstl [2];
  int mfls [2];

  function automatic int sc_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int max_of(input int k);
    return (k == 0) ? 15 : 65535;
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic       hzm;
      logic [4:0] ectl;
      int         est;
      logic [4:0] actl;
      logic [1:0] ast;
      int         astl, afls;
      if (reset) begin
        rem[k]  = 0;
        mstl[k] = 0;
        mfls[k] = 0;
      end
      hzm = ex_mem_read && (ex_rt != 0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
      est = (rem[k] > 0) ? 1 : 0;
      actl = (k == 0) ? ctl_a : ctl_b;
      ast  = (k == 0) ? st_a  : st_b;
      astl = (k == 0) ? int'(sc_a) : int'(sc_b);
      afls = (k == 0) ? int'(fc_a) : int'(fc_b);
      chk("state", k, 32'(ast), 32'(est));
      chk("stall_count", k, 32'(astl), 32'(mstl[k]));
      chk("flush_count", k, 32'(afls), 32'(mfls[k]));
      if (hold) begin
        ectl = 5'b00000;
      end else if (mem_redirect) begin
        ectl = 5'b11111;
        rem[k] = 0;
        if (mfls[k] < max_of(k)) mfls[k]++;
      end else if (rem[k] > 0 || hzm) begin
        ectl = 5'b00010;
        if (rem[k] == 0) rem[k] = sc_of(k);
        rem[k]--;
        if (mstl[k] < max_of(k)) mstl[k]++;
      end else begin
        ectl = 5'b11000;
      end
      chk("ctl", k, 32'(actl), 32'(ectl));
    end
  end

  task automatic step(input logic h, input logic red, input logic mr,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ert);
    @(posedge clk);
    #1;
    hold = h; mem_redirect = red; ex_mem_read = mr;
    id_rs = rs; id_rt = rt; ex_rt = ert;
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    hold = 0; mem_redirect = 0; ex_mem_read = 0;
    id_rs = 0; id_rt = 0; ex_rt = 0;
    reset = 1;
    @(negedge clk);
    #1;
    reset = 0;
  endtask

  initial begin
    reset = 1; hold = 0; mem_redirect = 0; ex_mem_read = 0;
    id_rs = 0; id_rt = 0; ex_rt = 0;
    #2;
    chk("rst_ctl", 1, 32'(ctl_b), 32'h18);
    chk("rst_state", 1, 32'(st_b), 32'h0);
    chk("rst_cnt", 1, 32'({sc_b, fc_b}), 32'h0);
    @(negedge clk);
    #1;
    reset = 0;

    // Load-use: one hazard cycle then MemRead drops
    step(0, 0, 1, 5'd5, 5'd0, 5'd5);
    chk("lu_pc_a", 0, 32'(ctl_a), 32'h02);
    chk("lu_pc_b", 1, 32'(ctl_b), 32'h02);
    step(0, 0, 0, 5'd5, 5'd0, 5'd5);
    chk("lu1_ctl_a", 0, 32'(ctl_a), 32'h18);
    chk("lu1_cnt_a", 0, 32'(sc_a), 32'd1);
    chk("lu1_st_a", 0, 32'(st_a), 32'd0);
    chk("lu3_c2_ctl", 1, 32'(ctl_b), 32'h02);
    chk("lu3_c2_st", 1, 32'(st_b), 32'd1);
    step(0, 0, 0, 5'd5, 5'd0, 5'd5);
    chk("lu3_c3_ctl", 1, 32'(ctl_b), 32'h02);
    chk("lu3_c3_st", 1, 32'(st_b), 32'd1);
    step(0, 0, 0, 5'd5, 5'd0, 5'd5);
    chk("lu3_end_ctl", 1, 32'(ctl_b), 32'h18);
    chk("lu3_end_st", 1, 32'(st_b), 32'd0);
    chk("lu3_end_cnt", 1, 32'(sc_b), 32'd3);

    // $zero and no-match
    step(0, 0, 1, 5'd0, 5'd0, 5'd0);
    chk("zero_pc", 1, 32'(pc_b), 32'd1);
    step(0, 0, 1, 5'd3, 5'd4, 5'd7);
    chk("nomatch_pc", 1, 32'(pc_b), 32'd1);

    // Redirect in the second stall cycle
    pulse_reset();
    step(0, 0, 1, 5'd5, 5'd0, 5'd5);
    step(0, 1, 0, 5'd0, 5'd0, 5'd0);
    chk("rd_stall_ctl", 1, 32'(ctl_b), 32'h1f);
    step(0, 0, 0, 5'd0, 5'd0, 5'd0);
    chk("rd_stall_st", 1, 32'(st_b), 32'd0);
    chk("rd_stall_fc", 1, 32'(fc_b), 32'd1);
    chk("rd_stall_sc", 1, 32'(sc_b), 32'd1);

    // Hold beats redirect; redirect taken on release
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 5'd0, 5'd0, 5'd0);
      chk("hold_ctl", 1, 32'(ctl_b), 32'h00);
      chk("hold_fc", 1, 32'(fc_b), 32'd1);
    end
    step(0, 1, 0, 5'd0, 5'd0, 5'd0);
    chk("rel_ctl", 1, 32'(ctl_b), 32'h1f);
    step(0, 0, 0, 5'd0, 5'd0, 5'd0);
    chk("rel_fc", 1, 32'(fc_b), 32'd2);

    // Asynchronous reset in the middle of a stall
    step(0, 0, 1, 5'd5, 5'd0, 5'd5);
    step(0, 0, 0, 5'd0, 5'd0, 5'd0);
    chk("pre_arst_st", 1, 32'(st_b), 32'd1);
    reset = 1;
    #1;
    chk("arst_st", 1, 32'(st_b), 32'd0);
    chk("arst_cnt", 1, 32'({sc_b, fc_b}), 32'd0);
    chk("arst_ctl", 1, 32'(ctl_b), 32'h18);
    @(negedge clk);
    #1;
    reset = 0;

    // Saturation of the 4-bit stall counter
    pulse_reset();
    repeat (14) step(0, 0, 1, 5'd5, 5'd0, 5'd5);
    step(0, 0, 0, 5'd0, 5'd0, 5'd0);
    chk("sat_14", 0, 32'(sc_a), 32'd14);
    repeat (2) step(0, 0, 1, 5'd5, 5'd0, 5'd5);
    step(0, 0, 0, 5'd0, 5'd0, 5'd0);
    chk("sat_15", 0, 32'(sc_a), 32'd15);
    step(0, 0, 1, 5'd5, 5'd0, 5'd5);
    step(0, 0, 0, 5'd0, 5'd0, 5'd0);
    chk("sat_hold", 0, 32'(sc_a), 32'd15);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) begin
        pulse_reset();
      end else begin
        step(($urandom_range(9) == 0), ($urandom_range(9) == 0), $urandom_range(1) == 1,
             5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)));
      end
    end
    step(0, 0, 0, 5'd0, 5'd0, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Sequencing controller for the five-stage MIPS pipeline. It detects load-use hazards between the ID and EX stages and stalls the front end for a configurable number of cycles. It flushes the three younger stages when a taken branch, jump or jr resolves in MEM, and honours an external freeze. It drives the PC write enable and the IF/ID, ID/EX and EX/MEM write/flush controls, and keeps saturating stall and flush event counters for debug.

## Interface
Parameters:
- STALL_CYCLES, default 1: bubbles inserted per load-use hazard; legal range 1..15.
- CNT_WIDTH, default 16: width of the event counters.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears state and counters.
- hold  input  1  external freeze; stops the whole pipeline.
- id_rs  input  5  rs field of the instruction in ID (bits 25:21).
- id_rt  input  5  rt field of the instruction in ID (bits 20:16).
- ex_rt  input  5  rt field of the instruction in EX.
- ex_mem_read  input  1  MemRead control of the instruction in EX.
- mem_redirect  input  1  taken branch, jump or jr resolved in MEM this cycle.
- pc_write  output  1  PC register load enable.
- if_id_write  output  1  IF/ID load enable.
- if_id_flush  output  1  IF/ID loads a bubble (all-zero instruction).
- id_ex_flush  output  1  ID/EX loads a bubble (all control bits 0).
- ex_mem_flush  output  1  EX/MEM loads a bubble (regWrite, memWrite, branch, jump and jr bits 0).
- state  output  2  FSM state: 0 = RUN, 1 = STALL.
- stall_count  output  CNT_WIDTH  cycles in which a stall bubble was inserted.
- flush_count  output  CNT_WIDTH  redirect flush events.

## Operation
- Hazard condition: hz = ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt).
- Output priority in each cycle: hold, then mem_redirect, then stall, then normal.
- hold = 1:
  - pc_write, if_id_write and all flushes are 0.
  - State, down-counter and event counters are frozen.
- mem_redirect = 1 with hold = 0:
  - pc_write = 1, if_id_write = 1.
  - if_id_flush, id_ex_flush and ex_mem_flush are all 1.
  - Next state is RUN and the down-counter is cleared.
  - flush_count increments.
- Stall cycle (RUN with hz, or any STALL cycle; no redirect, no hold):
  - pc_write = 0, if_id_write = 0, id_ex_flush = 1, the other flushes 0.
  - stall_count increments.
- Normal cycle: pc_write = 1, if_id_write = 1, all flushes 0.
- FSM transitions:
  - RUN with hz: if STALL_CYCLES == 1, stay in RUN; the next cycle re-evaluates hz with the bubble now in EX. Otherwise go to STALL and load cnt = STALL_CYCLES - 1.
  - STALL: decrement cnt each non-hold cycle. When cnt == 1, return to RUN at that edge.
  - In STALL, hz is ignored, because the original hazard is still being serviced.
- Counters saturate at all-ones and do not wrap.
- ex_rt == 0 never stalls, since $zero is never a hazard.

## Timing
- Stall and flush outputs are combinational from the inputs and the registered state. The pipeline registers act on them at the same rising edge.
- Latency from hazard detection to the first bubble: 0 cycles. The bubble is loaded into ID/EX at the edge that ends the detection cycle.
- Load-use stall length: exactly STALL_CYCLES cycles of pc_write = 0.
- A redirect flush takes 1 cycle. The PC loads the target at the same edge that the three stages load bubbles.
- Simultaneous redirect and hz, or redirect during STALL: the redirect wins and the stall is abandoned.
- Simultaneous hold and redirect: the freeze wins. The redirect is taken on the first cycle after hold falls, provided mem_redirect is still asserted; MEM is frozen, so it is.
- Reset value of every output:
  - pc_write = 1, if_id_write = 1, all flushes 0.
  - state = 0, both counters 0, cnt = 0.
  - These hold immediately on reset assertion, independent of clk, whenever hold, hz and mem_redirect are 0.
- Reset asserted mid-stall returns the FSM to RUN asynchronously. No residual stall follows deassertion.

## Test plan
- Load-use, STALL_CYCLES=1: ex_mem_read=1, ex_rt=5, id_rs=5 for one cycle, then ex_mem_read=0 -> exactly 1 cycle of pc_write=0 and id_ex_flush=1; stall_count=1; state stays 0.
- Load-use, STALL_CYCLES=3: same stimulus -> 3 consecutive stall cycles; state=1 for cycles 1–2 and 0 afterwards; stall_count=3.
- $zero and no-match: ex_rt=0 with id_rs=0, then ex_rt=7 with id_rs=3, id_rt=4 -> no stall; pc_write stays 1.
- Redirect during STALL (STALL_CYCLES=3): mem_redirect=1 in the second stall cycle -> all three flushes 1 and pc_write=1 that cycle; state=0 next cycle; flush_count=1; stall_count=1.
- Hold: hold=1 for 4 cycles with mem_redirect=1 -> all enables and flushes 0 and counters unchanged. On hold release, one flush cycle occurs and flush_count increments by 1.
- Reset and saturation: force stall_count to 0xFFFE via 0xFFFE stall cycles, then 2 more -> stall_count=0xFFFF. Asynchronous reset mid-STALL -> state=0 and counters=0 before the next clk edge.
